// File: rtl/cache_line_xfer.sv
// Line-transfer engine between the cache and an SRAM-like bus: dirty-line writeback
// bursts and refill bursts (optionally critical-word-first), one beat outstanding.
module cache_line_xfer #(
  parameter int LINE_WORDS = 8,
  parameter int CWF        = 0,
  parameter int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ren,
  input  logic [31:0]             raddr,
  output logic                    raccept,
  output logic                    wen_fill,
  output logic [32*LINE_WORDS-1:0] wfill,
  input  logic                    wen,
  input  logic [31:0]             waddr,
  input  logic [32*LINE_WORDS-1:0] wdata,
  output logic                    wfin,
  output logic                    sram_en,
  output logic [3:0]              sram_wen,
  output logic [31:0]             sram_addr,
  output logic [31:0]             sram_wdata,
  input  logic [31:0]             sram_rdata,
  input  logic                    sram_ok
);

  localparam int               LW       = 32 * LINE_WORDS;
  localparam logic [31:0]      OFF_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [OFF_W-1:0] LAST     = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WB, RD, FILL} state_t;

  state_t           state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic [OFF_W-1:0] start_q, start_d;
  logic [31:0]      base_q, base_d;
  logic [LW-1:0]    line_q, line_d;
  logic [LW-1:0]    wfill_q, wfill_d;
  logic             en_q, en_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdat_q, wdat_d;
  logic             raccept_q, raccept_d;
  logic             wfin_q, wfin_d;
  logic             fill_q, fill_d;

  logic [OFF_W-1:0] slot_s, nslot_s, rstart_s;
  logic             beat_done_s;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [OFF_W-1:0] idx);
    return base | 32'({idx, 2'b00});
  endfunction

  // Writebacks always start at word 0, so slot = start + beat serves both directions.
  assign slot_s      = start_q + beat_q;
  assign nslot_s     = slot_s + OFF_W'(1);
  assign rstart_s    = (CWF != 0) ? raddr[OFF_W+1:2] : '0;
  assign beat_done_s = en_q & sram_ok;

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    start_d   = start_q;
    base_d    = base_q;
    line_d    = line_q;
    wfill_d   = wfill_q;
    en_d      = en_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    raccept_d = 1'b0;
    wfin_d    = 1'b0;
    fill_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // wen is still held during the wfin cycle; it belongs to the burst just finished.
        if (wen && !wfin_q) begin
          base_d  = waddr & ~OFF_MASK;
          line_d  = wdata;
          beat_d  = '0;
          start_d = '0;
          en_d    = 1'b1;
          be_d    = 4'hF;
          addr_d  = word_addr(waddr & ~OFF_MASK, '0);
          wdat_d  = wdata[31:0];
          state_d = WB;
        end else if (ren) begin
          base_d    = raddr & ~OFF_MASK;
          beat_d    = '0;
          start_d   = rstart_s;
          raccept_d = 1'b1;
          en_d      = 1'b1;
          be_d      = 4'h0;
          addr_d    = word_addr(raddr & ~OFF_MASK, rstart_s);
          wdat_d    = 32'h0;
          state_d   = RD;
        end else begin
          en_d = 1'b0;
        end
      end
      WB: begin
        if (beat_done_s) begin
          if (beat_q == LAST) begin
            en_d    = 1'b0;
            be_d    = 4'h0;
            addr_d  = 32'h0;
            wdat_d  = 32'h0;
            wfin_d  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + OFF_W'(1);
            addr_d = word_addr(base_q, nslot_s);
            wdat_d = line_q[32*nslot_s +: 32];
          end
        end else begin
          state_d = WB;
        end
      end
      RD: begin
        if (beat_done_s) begin
          line_d[32*slot_s +: 32] = sram_rdata;
          if (beat_q == LAST) begin
            en_d    = 1'b0;
            addr_d  = 32'h0;
            wfill_d = line_d;
            fill_d  = 1'b1;
            state_d = FILL;
          end else begin
            beat_d = beat_q + OFF_W'(1);
            addr_d = word_addr(base_q, nslot_s);
          end
        end else begin
          state_d = RD;
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any burst silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      start_q   <= '0;
      base_q    <= 32'h0;
      line_q    <= '0;
      wfill_q   <= '0;
      en_q      <= 1'b0;
      be_q      <= 4'h0;
      addr_q    <= 32'h0;
      wdat_q    <= 32'h0;
      raccept_q <= 1'b0;
      wfin_q    <= 1'b0;
      fill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      start_q   <= start_d;
      base_q    <= base_d;
      line_q    <= line_d;
      wfill_q   <= wfill_d;
      en_q      <= en_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      raccept_q <= raccept_d;
      wfin_q    <= wfin_d;
      fill_q    <= fill_d;
    end
  end

  assign raccept    = raccept_q;
  assign wen_fill   = fill_q;
  assign wfill      = wfill_q;
  assign wfin       = wfin_q;
  assign sram_en    = en_q;
  assign sram_wen   = be_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdat_q;

endmodule

// File: tb/tb_cache_line_xfer.sv
// Directed bench for cache_line_xfer: three instances (8/CWF0, 8/CWF1, 4/CWF1).
module tb_cache_line_xfer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [31:0]  raddr, waddr;
  logic [255:0] wdata8;
  logic [127:0] wdata4;
  logic         ok;
  logic         ren_a, wen_a, ren_b, wen_b, ren_c, wen_c;

  logic         racc_a, fill_a, wfin_a, en_a;
  logic [255:0] wfill_a;
  logic [3:0]   be_a;
  logic [31:0]  addr_a, wd_a, rd_a;
  logic         racc_b, fill_b, wfin_b, en_b;
  logic [255:0] wfill_b;
  logic [3:0]   be_b;
  logic [31:0]  addr_b, wd_b, rd_b;
  logic         racc_c, fill_c, wfin_c, en_c;
  logic [127:0] wfill_c;
  logic [3:0]   be_c;
  logic [31:0]  addr_c, wd_c, rd_c;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

  logic [31:0]  offs8 [8] = '{32'h14, 32'h18, 32'h1C, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
  logic [31:0]  offs4 [4] = '{32'h0C, 32'h00, 32'h04, 32'h08};
  logic [255:0] lm;

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return a ^ 32'h5EED_1234;
  endfunction

  function automatic logic [255:0] line_model(input logic [31:0] base, input int n);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[32*k +: 32] = dfun(base + 32'(4 * k));
    return r;
  endfunction

  assign rd_a = dfun(addr_a);
  assign rd_b = dfun(addr_b);
  assign rd_c = dfun(addr_c);

  cache_line_xfer #(.LINE_WORDS(8), .CWF(0)) u_a (
    .clk(clk), .rst(rst), .ren(ren_a), .raddr(raddr), .raccept(racc_a), .wen_fill(fill_a),
    .wfill(wfill_a), .wen(wen_a), .waddr(waddr), .wdata(wdata8), .wfin(wfin_a), .sram_en(en_a),
    .sram_wen(be_a), .sram_addr(addr_a), .sram_wdata(wd_a), .sram_rdata(rd_a), .sram_ok(ok));

  cache_line_xfer #(.LINE_WORDS(8), .CWF(1)) u_b (
    .clk(clk), .rst(rst), .ren(ren_b), .raddr(raddr), .raccept(racc_b), .wen_fill(fill_b),
    .wfill(wfill_b), .wen(wen_b), .waddr(waddr), .wdata(wdata8), .wfin(wfin_b), .sram_en(en_b),
    .sram_wen(be_b), .sram_addr(addr_b), .sram_wdata(wd_b), .sram_rdata(rd_b), .sram_ok(ok));

  cache_line_xfer #(.LINE_WORDS(4), .CWF(1)) u_c (
    .clk(clk), .rst(rst), .ren(ren_c), .raddr(raddr), .raccept(racc_c), .wen_fill(fill_c),
    .wfill(wfill_c), .wen(wen_c), .waddr(waddr), .wdata(wdata4), .wfin(wfin_c), .sram_en(en_c),
    .sram_wen(be_c), .sram_addr(addr_c), .sram_wdata(wd_c), .sram_rdata(rd_c), .sram_ok(ok));

  task automatic check1(input string tag, input logic o, input logic e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, o, e);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] o, input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  task automatic check256(input string tag, input logic [255:0] o, input logic [255:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; ok = 1'b1; raddr = 32'h0; waddr = 32'h0; wdata8 = '0; wdata4 = '0;
    ren_a = 1'b0; wen_a = 1'b0; ren_b = 1'b0; wen_b = 1'b0; ren_c = 1'b0; wen_c = 1'b0;
    #1 rst = 1'b0;
    #2;
    check1("rst_en", en_a, 1'b0);
    check1("rst_racc", racc_a, 1'b0);
    check1("rst_fill", fill_a, 1'b0);
    check1("rst_wfin", wfin_a, 1'b0);
    check256("rst_wfill", wfill_a, 256'h0);
    #10 rst = 1'b1;
    step();

    // T1: refill, CWF=0, always starts at word 0
    cyc = 0; ren_a = 1'b1; raddr = 32'h1000_0014;
    step();
    check1("t1_racc", racc_a, 1'b1);
    ren_a = 1'b0; raddr = 32'hFFFF_FFFC;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        step();
        check1("t1_racc_low", racc_a, 1'b0);
      end
      check1("t1_en", en_a, 1'b1);
      check32("t1_be", {28'h0, be_a}, 32'h0);
      check32("t1_addr", addr_a, 32'h1000_0000 + 32'(4 * k));
    end
    step();
    check1("t1_fill", fill_a, 1'b1);
    check1("t1_en_off", en_a, 1'b0);
    check256("t1_wfill", wfill_a, line_model(32'h1000_0000, 8));
    step();
    check1("t1_fill_off", fill_a, 1'b0);
    check256("t1_wfill_hold", wfill_a, line_model(32'h1000_0000, 8));

    // T2: refill, CWF=1, starts at word 5 and wraps
    cyc = 0; ren_b = 1'b1; raddr = 32'h1000_0014;
    step();
    check1("t2_racc", racc_b, 1'b1);
    ren_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      check1("t2_en", en_b, 1'b1);
      check32("t2_addr", addr_b, 32'h1000_0000 + offs8[k]);
    end
    step();
    check1("t2_fill", fill_b, 1'b1);
    check256("t2_wfill", wfill_b, line_model(32'h1000_0000, 8));
    check32("t2_word5", wfill_b[160 +: 32], dfun(32'h1000_0014));

    // T3: writeback wins over simultaneous refill; refill follows wfin
    step();
    cyc = 0; wen_a = 1'b1; ren_a = 1'b1; waddr = 32'h2000_0020; raddr = 32'h1000_0040;
    for (int k = 0; k < 8; k++) wdata8[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
    step();
    check1("t3_racc_blocked", racc_a, 1'b0);
    wdata8 = '0; waddr = 32'h0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      check1("t3_en", en_a, 1'b1);
      check32("t3_be", {28'h0, be_a}, 32'h0000_000F);
      check32("t3_addr", addr_a, 32'h2000_0020 + 32'(4 * k));
      check32("t3_wdata", wd_a, 32'hC0DE_0000 + 32'(k));
      check1("t3_wfin_low", wfin_a, 1'b0);
    end
    step();
    check1("t3_wfin", wfin_a, 1'b1);
    check1("t3_en_off", en_a, 1'b0);
    step();
    wen_a = 1'b0;
    check1("t3_racc", racc_a, 1'b1);
    check1("t3_wfin_off", wfin_a, 1'b0);
    check32("t3_raddr0", addr_a, 32'h1000_0040);
    check32("t3_rbe", {28'h0, be_a}, 32'h0);
    ren_a = 1'b0;
    for (int k = 1; k < 9; k++) step();
    check1("t3_fill", fill_a, 1'b1);
    check256("t3_wfill", wfill_a, line_model(32'h1000_0040, 8));

    // T4: three-cycle stall on beat 2
    step();
    cyc = 0; ren_a = 1'b1; raddr = 32'h1000_0080;
    step();
    check1("t4_racc", racc_a, 1'b1);
    ren_a = 1'b0;
    step();
    step();
    ok = 1'b0;
    for (int k = 3; k < 7; k++) begin
      if (k > 3) step();
      if (k == 6) ok = 1'b1;
      check1("t4_stall_en", en_a, 1'b1);
      check32("t4_stall_addr", addr_a, 32'h1000_0088);
    end
    step();
    check32("t4_addr_b3", addr_a, 32'h1000_008C);
    for (int k = 8; k < 12; k++) step();
    check1("t4_fill_early", fill_a, 1'b0);
    step();
    check1("t4_fill", fill_a, 1'b1);
    check256("t4_wfill", wfill_a, line_model(32'h1000_0080, 8));

    // T5: asynchronous reset mid-refill at beat 4
    step();
    cyc = 0; ren_a = 1'b1; raddr = 32'h1000_00C0;
    step();
    ren_a = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check32("t5_addr_b4", addr_a, 32'h1000_00D0);
    #2 rst = 1'b0;
    #1;
    check1("t5_en", en_a, 1'b0);
    check32("t5_addr", addr_a, 32'h0);
    check1("t5_fill", fill_a, 1'b0);
    check256("t5_wfill", wfill_a, 256'h0);
    #2 rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check1("t5_no_fill", fill_a, 1'b0);
      check1("t5_idle_en", en_a, 1'b0);
    end
    cyc = 0; ren_a = 1'b1; raddr = 32'h1000_0100;
    step();
    check1("t5_racc", racc_a, 1'b1);
    check32("t5_addr0", addr_a, 32'h1000_0100);
    ren_a = 1'b0;
    for (int k = 1; k < 9; k++) step();
    check1("t5_refill", fill_a, 1'b1);
    check256("t5_rwfill", wfill_a, line_model(32'h1000_0100, 8));

    // T6: 4-word line, CWF=1, miss on word 3
    step();
    cyc = 0; ren_c = 1'b1; raddr = 32'h3000_000C;
    step();
    check1("t6_racc", racc_c, 1'b1);
    ren_c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      check1("t6_en", en_c, 1'b1);
      check32("t6_addr", addr_c, 32'h3000_0000 + offs4[k]);
    end
    step();
    check1("t6_fill", fill_c, 1'b1);
    lm = line_model(32'h3000_0000, 4);
    check256("t6_wfill", 256'(wfill_c), {128'h0, lm[127:0]});
    step();
    check1("t6_fill_off", fill_c, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/cache_line_xfer.md
Name: cache_line_xfer

Overview:
- Line-transfer engine between the cache and the SRAM-like bus, successor to the refill-only interface.
- Performs both dirty-line writeback bursts and refill bursts.
- Line size is parametrised; an optional critical-word-first (CWF) wrap mode is provided for refills.
- Sits between the cache miss/victim logic and the bus control interface; one bus request is outstanding at a time.

Parameters:
- LINE_WORDS, 8: 32-bit words per cache line; power of two, minimum 2.
- CWF, 0: 1 = refill starts at the missed word and wraps; 0 = refill always starts at word 0.
- OFF_W, $clog2(LINE_WORDS): word-offset width (derived; do not override).

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- ren, in, 1: refill request; held high until raccept.
- raddr, in, 32: miss address; bits [1:0] ignored.
- raccept, out, 1: one-cycle pulse when the refill request is captured.
- wen_fill, out, 1: one-cycle pulse; wfill is valid in that cycle.
- wfill, out, 32*LINE_WORDS: assembled line; word k is at [k*32 +: 32].
- wen, in, 1: writeback request; held high until wfin.
- waddr, in, 32: victim line address; offset bits ignored.
- wdata, in, 32*LINE_WORDS: victim line; sampled with wen.
- wfin, out, 1: one-cycle pulse when the last writeback word is acknowledged.
- sram_en, out, 1: bus request valid.
- sram_wen, out, 4: byte enables; 4'hF for writes, 4'h0 for reads.
- sram_addr, out, 32: word address.
- sram_wdata, out, 32: write data.
- sram_rdata, in, 32: read data; valid only when sram_ok is high during a read.
- sram_ok, in, 1: transfer complete for the current beat.

Behaviour:
- Reset (rst low, asynchronous): all outputs go to 0, state = IDLE, offset counters clear. An in-flight burst is abandoned with no wfin or wen_fill pulse.
- States: IDLE, WB, RD, FILL.
- IDLE:
  - wen high: latch wdata and line base (waddr with low OFF_W+2 bits cleared) -> WB. Writeback has priority when wen and ren are high in the same cycle.
  - Otherwise ren high: latch line base and start word s = raddr[OFF_W+1:2] (s = 0 when CWF = 0), pulse raccept -> RD.
- Beat rule: a beat completes on any edge where sram_en && sram_ok. sram_en, sram_addr, sram_wen and sram_wdata are registered and stay stable until the beat completes. After a completed non-final beat, the next beat is presented on the following cycle with sram_en still high. With sram_ok tied high, the engine sustains 1 word per cycle.
- WB:
  - Beat i (i = 0..LINE_WORDS-1) drives addr = base + 4*i, wdata = word i, wen = 4'hF.
  - Last beat completes: sram_en = 0, wfin = 1 for one cycle, state -> IDLE.
  - The IDLE evaluation may run in that same wfin cycle, so a pending ren gives raccept on the next cycle.
- RD:
  - Beat i drives addr = base + 4*((s+i) mod LINE_WORDS) with wen = 0. The word index wraps modulo LINE_WORDS; the address never leaves the line.
  - sram_rdata is stored at word slot (s+i) mod LINE_WORDS.
  - Last beat -> FILL with sram_en = 0.
- FILL: wen_fill = 1 and wfill = the full line for exactly one cycle, then -> IDLE.
- Timing, refill with sram_ok tied high (ren sampled at cycle 0):
  - cycle 1: raccept and first sram_en.
  - cycles 1..LINE_WORDS: beats.
  - cycle LINE_WORDS+1: wen_fill.
  - cycle LINE_WORDS+2: IDLE.
- Timing, writeback (wen sampled at cycle 0): beats in cycles 1..LINE_WORDS, wfin in cycle LINE_WORDS+1.
- Request handling while busy:
  - ren or wen raised while busy is ignored until the engine returns to IDLE.
  - Inputs are held by the requester, so nothing is lost.
  - raddr and waddr changes after capture have no effect.
- sram_ok while sram_en is low is ignored.
- sram_ok stalls of any length are legal; there is no timeout.
- wfill holds its last value between pulses.

Test Plan:
- LINE_WORDS=8, CWF=0, sram_ok=1, ren with raddr=0x1000_0014 -> raccept at cycle 1; reads of 0x1000_0000..0x1000_001C in order; wen_fill at cycle 9 with word k = sram_rdata of beat k.
- CWF=1, raddr=0x1000_0014 -> read order 0x14,0x18,0x1C,0x00,0x04,0x08,0x0C,0x10 (offsets on base 0x1000_0000); wfill word 5 = first data returned; wen_fill at cycle 9.
- wen and ren high together at cycle 0, waddr=0x2000_0020 -> 8 writes 0x2000_0020..0x2000_003C with sram_wen=4'hF; wfin at cycle 9; raccept at cycle 10; then refill proceeds normally.
- Refill with sram_ok low for 3 cycles on beat 2 -> sram_addr and sram_en held stable through the stall; wen_fill delayed by exactly 3 cycles (cycle 12).
- rst pulled low mid-refill at beat 4 -> all outputs 0 immediately without a clock edge; after release, no wen_fill occurs; a new ren starts cleanly from beat 0.
- LINE_WORDS=4, CWF=1, raddr word 3 -> order 3,0,1,2; wfill width 128; wen_fill at cycle 5.
